// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for the ID stage. Each tracked register has a
// countdown to the cycle its pending result appears on the WB result bus.
module hazard_scoreboard #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NRP    = 2,
  parameter int MAXLAT = 7,
  parameter int CW     = 3,
  parameter int PCW    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [AW-1:0]     issue_rd,
  input  logic [CW-1:0]     issue_lat,
  input  logic              flush,
  input  logic [NRP-1:0]    rs_valid,
  input  logic [NRP*AW-1:0] rs,
  output logic              stall,
  output logic              raw_stall,
  output logic              waw_stall,
  output logic [NRP-1:0]    fwd_wb,
  output logic              busy,
  output logic [PCW-1:0]    stall_cnt
);

  logic [CW-1:0]  cnt_q [NREG];
  logic [CW-1:0]  cnt_d [NREG];
  logic [PCW-1:0] stall_cnt_q, stall_cnt_d;

  logic [CW-1:0]  lat_n;
  logic [CW-1:0]  rd_cnt;
  logic [AW-1:0]  src_addr [NRP];
  logic [CW-1:0]  src_cnt [NRP];
  logic [NRP-1:0] src_live;
  logic [NRP-1:0] not_ready;
  logic           rd_live;
  logic           accept;

  // A zero latency still needs one cycle to reach the bus; clamp the top end.
  always_comb begin
    if (issue_lat == '0) begin
      lat_n = CW'(1);
    end else if (issue_lat > CW'(MAXLAT)) begin
      lat_n = CW'(MAXLAT);
    end else begin
      lat_n = issue_lat;
    end
  end

  always_comb begin
    rd_cnt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (issue_rd == AW'(r)) begin
        rd_cnt = cnt_q[r];
      end
    end
    for (int p = 0; p < NRP; p++) begin
      src_addr[p] = rs[p*AW +: AW];
      src_live[p] = rs_valid[p] & (src_addr[p] != '0);
      src_cnt[p]  = '0;
      for (int r = 1; r < NREG; r++) begin
        if (src_addr[p] == AW'(r)) begin
          src_cnt[p] = cnt_q[r];
        end
      end
    end
  end

  // A count of 1 means the producer's result is on the WB bus right now.
  always_comb begin
    for (int p = 0; p < NRP; p++) begin
      fwd_wb[p]    = src_live[p] & (src_cnt[p] == CW'(1));
      not_ready[p] = src_live[p] & (src_cnt[p] > CW'(1));
    end
  end

  assign rd_live   = issue_we & (issue_rd != '0);
  assign raw_stall = issue_valid & ~flush & (|not_ready);
  assign waw_stall = issue_valid & ~flush & rd_live & (lat_n < rd_cnt);
  assign stall     = raw_stall | waw_stall;
  assign accept    = issue_valid & rd_live & ~stall & ~flush;

  // An accepted write re-arms its counter in place of the normal decrement.
  always_comb begin
    busy     = 1'b0;
    cnt_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
      if (accept && (issue_rd == AW'(r))) begin
        cnt_d[r] = lat_n;
      end
      busy = busy | (cnt_q[r] != '0);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

  localparam int AW  = 5;
  localparam int CW  = 3;
  localparam int NRP = 2;
  localparam int PCW = 8;

  typedef struct {
    string       name;
    logic [13:0] vec;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_valid;
  logic              issue_we;
  logic [AW-1:0]     issue_rd;
  logic [CW-1:0]     issue_lat;
  logic              flush;
  logic [NRP-1:0]    rs_valid;
  logic [NRP*AW-1:0] rs;
  logic              stall;
  logic              raw_stall;
  logic              waw_stall;
  logic [NRP-1:0]    fwd_wb;
  logic              busy;
  logic [PCW-1:0]    stall_cnt;

  exp_t expQ[$];
  int   checkCount = 0;
  int   errorCount = 0;

  hazard_scoreboard #(
    .NREG(32), .AW(AW), .NRP(NRP), .MAXLAT(7), .CW(CW), .PCW(PCW)
  ) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush),
    .rs_valid(rs_valid), .rs(rs), .stall(stall), .raw_stall(raw_stall),
    .waw_stall(waw_stall), .fwd_wb(fwd_wb), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the edge; optionally queue the expectation.
  task automatic applyStimulus(input string name, input logic rst, input logic v,
                               input logic we, input int rd, input int lat,
                               input logic fl, input logic [1:0] rsv,
                               input int s0, input int s1,
                               input logic es, input logic er, input logic ew,
                               input logic [1:0] ef, input logic eb,
                               input int esc, input logic chk);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    issue_valid = v;
    issue_we    = we;
    issue_rd    = AW'(rd);
    issue_lat   = CW'(lat);
    flush       = fl;
    rs_valid    = rsv;
    rs          = {AW'(s1), AW'(s0)};
    if (chk) begin
      e.name = name;
      e.vec  = {es, er, ew, ef, eb, 8'(esc)};
      expQ.push_back(e);
    end
  endtask

  task automatic idleCycle(input string name, input logic eb, input int esc,
                           input logic chk);
    applyStimulus(name, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 2'b00, 0, 0,
                  1'b0, 1'b0, 1'b0, 2'b00, eb, esc, chk);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [13:0] act;
    act = {stall, raw_stall, waw_stall, fwd_wb, busy, stall_cnt};
    checkCount++;
    if (act !== e.vec) begin
      errorCount++;
      $display("[TB] FAIL %s: {stall,raw,waw,fwd[1:0],busy,cnt[7:0]} got %b expected %b",
               e.name, act, e.vec);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0;
    issue_lat = '0; flush = 1'b0; rs_valid = '0; rs = '0;

    applyStimulus("reset", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);

    // ALU producer forwarded from WB the next cycle
    applyStimulus("alu_issue_r8", 0, 1, 1, 8, 1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    applyStimulus("alu_fwd_r8",   0, 1, 0, 0, 0, 0, 2'b01, 8, 0, 0, 0, 0, 2'b01, 1, 0, 1);
    applyStimulus("alu_retired",  0, 1, 0, 0, 0, 0, 2'b01, 8, 0, 0, 0, 0, 2'b00, 0, 0, 1);

    // Load-use on port 1
    applyStimulus("load_issue_r9",  0, 1, 1, 9, 2, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    applyStimulus("load_use_stall", 0, 1, 0, 0, 0, 0, 2'b10, 0, 9, 1, 1, 0, 2'b00, 1, 0, 1);
    applyStimulus("load_use_fwd",   0, 1, 0, 0, 0, 0, 2'b10, 0, 9, 0, 0, 0, 2'b10, 1, 1, 1);

    // Latency-7 producer: reader waits while count is 7..2
    applyStimulus("mul_issue_r10", 0, 1, 1, 10, 7, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus("mul_use_stall", 0, 1, 0, 0, 0, 0, 2'b01, 10, 0,
                    1, 1, 0, 2'b00, 1, 1 + i, 1);
    end
    applyStimulus("mul_use_fwd",  0, 1, 0, 0, 0, 0, 2'b01, 10, 0, 0, 0, 0, 2'b01, 1, 7, 1);
    applyStimulus("mul_regfile",  0, 1, 0, 0, 0, 0, 2'b01, 10, 0, 0, 0, 0, 2'b00, 0, 7, 1);

    // WAW: a faster younger write to r11 waits until it cannot overtake
    applyStimulus("mul_issue_r11", 0, 1, 1, 11, 6, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 7, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("waw_stall", 0, 1, 1, 11, 0, 0, 2'b00, 0, 0,
                    1, 0, 1, 2'b00, 1, 7 + i, 1);
    end
    applyStimulus("waw_accept",      0, 1, 1, 11, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 12, 1);
    applyStimulus("waw_younger_fwd", 0, 1, 0, 0, 0, 0, 2'b01, 11, 0, 0, 0, 0, 2'b01, 1, 12, 1);
    idleCycle("waw_retired", 0, 12, 1);

    // Flushed instruction neither stalls nor allocates; r12 keeps counting
    applyStimulus("issue_r12",    0, 1, 1, 12, 3, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 12, 1);
    applyStimulus("flush_reader", 0, 1, 1, 20, 5, 1, 2'b01, 12, 0, 0, 0, 0, 2'b00, 1, 12, 1);
    idleCycle("flush_cnt2", 1, 12, 1);
    idleCycle("flush_cnt1", 1, 12, 1);
    idleCycle("flush_no_entry", 0, 12, 1);

    // Register 0 is never tracked
    applyStimulus("r0_write", 0, 1, 1, 0, 7, 0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 0, 12, 1);
    applyStimulus("r0_read",  0, 1, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 0, 12, 1);

    // Same register on both ports; unused ports and idle ID never stall
    applyStimulus("issue_r7",      0, 1, 1, 7, 1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 12, 1);
    applyStimulus("dual_port_fwd", 0, 1, 0, 0, 0, 0, 2'b11, 7, 7, 0, 0, 0, 2'b11, 1, 12, 1);
    applyStimulus("issue_r6",      0, 1, 1, 6, 3, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 12, 1);
    applyStimulus("unused_ports",  0, 1, 0, 0, 0, 0, 2'b00, 6, 6, 0, 0, 0, 2'b00, 1, 12, 1);
    applyStimulus("no_issue",      0, 0, 0, 0, 0, 0, 2'b01, 6, 0, 0, 0, 0, 2'b00, 1, 12, 1);
    idleCycle("r6_cnt1", 1, 12, 1);
    idleCycle("r6_retired", 0, 12, 1);

    // Reset mid-operation beats a simultaneous issue
    applyStimulus("issue_r5",    0, 1, 1, 5, 4, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 12, 1);
    applyStimulus("reset_mid",   1, 1, 1, 5, 4, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 12, 1);
    idleCycle("after_reset", 0, 0, 1);

    // Sustained stalls: reader/writer of r4 stalls 6 of every 7 cycles
    applyStimulus("issue_r4", 0, 1, 1, 4, 7, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    for (int i = 0; i < 350; i++) begin
      applyStimulus("sat_loop", 0, 1, 1, 4, 7, 0, 2'b01, 4, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      idleCycle("sat_drain", 0, 0, 0);
    end
    idleCycle("sat_drained", 0, 255, 1);
    applyStimulus("issue_r3",  0, 1, 1, 3, 2, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 255, 1);
    applyStimulus("sat_stall", 0, 1, 0, 0, 0, 0, 2'b01, 3, 0, 1, 1, 0, 2'b00, 1, 255, 1);
    idleCycle("sat_hold", 1, 255, 1);

    @(negedge clk);
    #1;
    checkCount++;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
